minimac2_rx_sched: RTL and testbench
====================================

Name: minimac2_rx_sched

Overview:
Single-clock scheduler that owns the two RX packet buffers (slot 0 / slot 1) of the minimac2 memory.
- Tracks per-slot ownership state and assigns each incoming frame to an armed slot.
- Commits the frame length on completion and raises an interrupt.
- Exposes a small CSR window so software can arm, read and release slots.
- Sits between the sys_clk-side RX engine handshake and the minimac2 CSR decoder; its rx_slot_sel steers rxb0/rxb1 write enables.

Parameters:
- NSLOT_W, 1, slot index width (fixed 2 slots; not to be changed).
- LEN_W, 11, frame length width; matches the 2 KiB buffer depth.
- DROP_W, 16, drop counter width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous reset, active-low.
- csr_we  in  1  CSR write strobe.
- csr_adr  in  3  CSR word address.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered.
- rx_start  in  1  pulse: RX engine begins a frame.
- rx_done  in  1  pulse: frame ended good.
- rx_err  in  1  pulse: frame ended bad (CRC/overrun).
- rx_len  in  LEN_W  byte count; valid with rx_done.
- rx_ready  out  1  at least one slot armed and not busy.
- rx_active  out  1  frame currently being written into a slot.
- rx_slot_sel  out  1  target slot of current frame.
- irq  out  1  any slot FULL.

Behaviour:
- Slot state encoding, 2 bits: DISABLED=0, ARMED=1, FULL=2; value 3 is never stored.
- Reset (async on sys_rst_n low): both slots DISABLED, lengths 0, drop count 0, FSM IDLE, rr pointer 0. Outputs csr_do=0, rx_ready=0, rx_active=0, rx_slot_sel=0, irq=0.
- FSM has two states, IDLE and RECV.
- IDLE + rx_start with rx_ready=1:
  - Pick the ARMED slot; if both are ARMED, pick the rr pointer and then toggle it.
  - rx_slot_sel is registered: it is valid the cycle after rx_start and remains stable until the frame ends.
  - Go to RECV; rx_active=1.
- IDLE + rx_start with rx_ready=0: frame dropped; drop count +1, saturating at all-ones; stay IDLE.
- RECV + rx_done:
  - If rx_len != 0: slot becomes FULL and its length register = rx_len.
  - If rx_len == 0: slot stays ARMED.
  - Return to IDLE.
- RECV + rx_err: slot stays ARMED, length unchanged, return to IDLE.
- rx_done and rx_err in the same cycle: treated as rx_err.
- rx_start while in RECV: ignored. The engine never overlaps frames; an assertion flags it.
- rx_ready = IDLE and at least one slot ARMED. It is combinational from registered state.
- irq = slot0 FULL or slot1 FULL, registered: it asserts the cycle after commit.
- CSR map (word addresses):
  - 0: slot0 state
  - 1: slot0 length
  - 2: slot1 state
  - 3: slot1 length
  - 4: drop count
  - 5: status {rr, rx_active}
  - 6, 7: read 0
- CSR reads: csr_do updates on every cycle from csr_adr, with 1-cycle latency; unused bits read 0.
- CSR writes to state addresses accept csr_di[1:0] values 0 or 1 only. Writing 2 or 3 is ignored.
- CSR write to the slot currently selected while in RECV is ignored entirely. Hardware owns it until the frame ends.
- Same-cycle CSR write and hardware commit on different slots: both take effect.
- Writing addr 4 clears the drop count. If a drop occurs in the same cycle, the count ends at 1.
- Length and status registers are read-only; writes to them are ignored.

Optional Feature:
- Macro: MINIMAC2_RX_DROPCNT_EN.
- Defined: drop counter implemented as above; addr 4 is readable and clearable.
- Undefined: no counter flops; addr 4 reads 0; writes to it are ignored. Drop behaviour is otherwise identical: the frame is still ignored and the FSM stays IDLE.

Decomposition:
- Shared package minimac2_pkg holds:
  - slot state constants SLOT_DISABLED, SLOT_ARMED, SLOT_FULL;
  - CSR address constants RX_ADR_S0STATE through RX_ADR_STATUS;
  - LEN_W.
- One natural sub-module, minimac2_rx_slot: per-slot state and length register with arm/commit/abort/release inputs and a hardware-owned lock. It is instantiated twice; the top holds the FSM, the round-robin pointer, the drop counter and the CSR mux.

Test Plan:
- Arm slot0 (write addr0=1), rx_start, rx_done with rx_len=64 -> rx_slot_sel=0; addr0 reads 2, addr1 reads 64; irq rises 1 cycle after rx_done.
- Arm both, send three 100-byte frames, releasing after each -> slots used 0,1,0; rr toggles each time; irq drops after the writes of 1 to the FULL slots.
- No slot armed, send 5 rx_start pulses -> rx_ready=0 throughout; addr4 reads 5 (0 without macro); write addr4 -> reads 0.
- Arm slot1, rx_start, then write addr2=0 mid-frame, then rx_err -> write ignored; slot1 remains ARMED, length 0, no irq.
- Assert rx_done and rx_err in the same cycle with rx_len=200 -> slot stays ARMED, length unchanged, irq stays 0.
- Pull sys_rst_n low asynchronously during RECV -> all outputs 0 immediately; after release, both slots read 0 and rx_ready=0.

Source files
------------

// File: rtl/minimac2_pkg.sv
// Shared constants for the minimac2 RX slot scheduler: slot states, CSR word map, widths.
package minimac2_pkg;

   localparam int NSLOT_W = 1;
   localparam int LEN_W   = 11;
   localparam int DROP_W  = 16;

   localparam logic [1:0] SLOT_DISABLED = 2'd0;
   localparam logic [1:0] SLOT_ARMED    = 2'd1;
   localparam logic [1:0] SLOT_FULL     = 2'd2;

   localparam logic [2:0] RX_ADR_S0STATE = 3'd0;
   localparam logic [2:0] RX_ADR_S0LEN   = 3'd1;
   localparam logic [2:0] RX_ADR_S1STATE = 3'd2;
   localparam logic [2:0] RX_ADR_S1LEN   = 3'd3;
   localparam logic [2:0] RX_ADR_DROPCNT = 3'd4;
   localparam logic [2:0] RX_ADR_STATUS  = 3'd5;

   // Software may only disable or arm a slot; FULL is reachable by hardware only.
   function automatic logic slot_wr_ok(input logic [1:0] v);
      return !v[1];
   endfunction

endpackage

// File: rtl/minimac2_rx_slot.sv
// One RX buffer slot: ownership state plus committed frame length.
// Software writes are blocked while the RX engine owns the slot (lock).
module minimac2_rx_slot
   import minimac2_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             sw_we,
   input  logic [1:0]       sw_state,
   input  logic             lock,
   input  logic             commit,
   input  logic [LEN_W-1:0] commit_len,
   output logic [1:0]       state,
   output logic [LEN_W-1:0] len
);

   logic [1:0]       state_reg;
   logic [LEN_W-1:0] len_reg;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= SLOT_DISABLED;
         len_reg   <= '0;
      end else if (commit) begin
         state_reg <= SLOT_FULL;
         len_reg   <= commit_len;
      end else if (sw_we && !lock && slot_wr_ok(sw_state)) begin
         state_reg <= sw_state;
      end
   end

   assign state = state_reg;
   assign len   = len_reg;

endmodule

// File: rtl/minimac2_rx_sched.sv
// RX slot scheduler: assigns frames to armed slots (round-robin when both armed),
// commits lengths, raises irq and exposes a CSR window. Option: MINIMAC2_RX_DROPCNT_EN.
module minimac2_rx_sched
   import minimac2_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             csr_we,
   input  logic [2:0]       csr_adr,
   input  logic [31:0]      csr_di,
   output logic [31:0]      csr_do,
   input  logic             rx_start,
   input  logic             rx_done,
   input  logic             rx_err,
   input  logic [LEN_W-1:0] rx_len,
   output logic             rx_ready,
   output logic             rx_active,
   output logic             rx_slot_sel,
   output logic             irq
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   logic [0:0]       fsm_reg;
   logic             rr_reg;
   logic             sel_reg;
   logic             irq_reg;
   logic [31:0]      csr_do_reg;
   logic [31:0]      csr_do_next;
   logic [1:0]       slot_state [2];
   logic [LEN_W-1:0] slot_len [2];
   logic [DROP_W-1:0] drop_val;

   logic in_recv, any_armed, both_armed, accept, drop, commit_ok, pick;
   logic unused_ok;

   assign in_recv    = (fsm_reg == ST_RECV);
   assign any_armed  = (slot_state[0] == SLOT_ARMED) || (slot_state[1] == SLOT_ARMED);
   assign both_armed = (slot_state[0] == SLOT_ARMED) && (slot_state[1] == SLOT_ARMED);
   assign rx_ready   = !in_recv && any_armed;
   assign accept     = rx_start && rx_ready;
   assign drop       = rx_start && !in_recv && !any_armed;
   // rx_err wins over a simultaneous rx_done; zero-length frames leave the slot armed.
   assign commit_ok  = in_recv && rx_done && !rx_err && (rx_len != '0);
   assign pick       = both_armed ? rr_reg : (slot_state[0] != SLOT_ARMED);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         minimac2_rx_slot u_slot (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .sw_we      (csr_we && (csr_adr == 3'(2 * gi))),
            .sw_state   (csr_di[1:0]),
            .lock       (in_recv && (sel_reg == 1'(gi))),
            .commit     (commit_ok && (sel_reg == 1'(gi))),
            .commit_len (rx_len),
            .state      (slot_state[gi]),
            .len        (slot_len[gi])
         );
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         fsm_reg <= ST_IDLE;
         rr_reg  <= 1'b0;
         sel_reg <= 1'b0;
         irq_reg <= 1'b0;
      end else begin
         irq_reg <= (slot_state[0] == SLOT_FULL) || (slot_state[1] == SLOT_FULL);
         if (in_recv) begin
            if (rx_done || rx_err)
               fsm_reg <= ST_IDLE;
         end else if (accept) begin
            fsm_reg <= ST_RECV;
            sel_reg <= pick;
            if (both_armed)
               rr_reg <= ~rr_reg;
         end
      end
   end

`ifdef MINIMAC2_RX_DROPCNT_EN
   logic [DROP_W-1:0] drop_cnt_reg;
   logic [DROP_W-1:0] drop_cnt_next;

   // Clear is applied first so a same-cycle drop still counts.
   always_comb begin
      drop_cnt_next = drop_cnt_reg;
      if (csr_we && (csr_adr == RX_ADR_DROPCNT))
         drop_cnt_next = '0;
      if (drop && (drop_cnt_next != '1))
         drop_cnt_next = drop_cnt_next + 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         drop_cnt_reg <= '0;
      else
         drop_cnt_reg <= drop_cnt_next;
   end

   assign drop_val = drop_cnt_reg;
`else
   assign drop_val = '0;
`endif

   always_comb begin
      csr_do_next = '0;
      case (csr_adr)
         RX_ADR_S0STATE: csr_do_next = {30'd0, slot_state[0]};
         RX_ADR_S0LEN:   csr_do_next = 32'(slot_len[0]);
         RX_ADR_S1STATE: csr_do_next = {30'd0, slot_state[1]};
         RX_ADR_S1LEN:   csr_do_next = 32'(slot_len[1]);
         RX_ADR_DROPCNT: csr_do_next = 32'(drop_val);
         RX_ADR_STATUS:  csr_do_next = {30'd0, rr_reg, in_recv};
         default:        csr_do_next = '0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         csr_do_reg <= '0;
      else
         csr_do_reg <= csr_do_next;
   end

   assign csr_do      = csr_do_reg;
   assign rx_active   = in_recv;
   assign rx_slot_sel = sel_reg;
   assign irq         = irq_reg;
   assign unused_ok   = ^{csr_di[31:2], drop};

   a_no_overlap: assert property (@(posedge sys_clk) disable iff (!sys_rst_n) !(in_recv && rx_start));

endmodule

// File: tb/tb_minimac2_rx_sched.sv
// Randomized bench for minimac2_rx_sched against a transaction-level slot model.
module tb_minimac2_rx_sched;
   import minimac2_pkg::*;

`ifdef MINIMAC2_RX_DROPCNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        csr_we = 1'b0;
   logic [2:0]  csr_adr = '0;
   logic [31:0] csr_di = '0;
   logic [31:0] csr_do;
   logic        rx_start = 1'b0;
   logic        rx_done = 1'b0;
   logic        rx_err = 1'b0;
   logic [10:0] rx_len = '0;
   logic        rx_ready, rx_active, rx_slot_sel, irq;

   minimac2_rx_sched dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .csr_we      (csr_we),
      .csr_adr     (csr_adr),
      .csr_di      (csr_di),
      .csr_do      (csr_do),
      .rx_start    (rx_start),
      .rx_done     (rx_done),
      .rx_err      (rx_err),
      .rx_len      (rx_len),
      .rx_ready    (rx_ready),
      .rx_active   (rx_active),
      .rx_slot_sel (rx_slot_sel),
      .irq         (irq)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: slot ownership as plain integers (0 disabled, 1 armed, 2 full)
   int m_state [2];
   int m_len [2];
   int m_drop;
   bit m_rr, m_recv, m_sel;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit m_ready();
      return !m_recv && (m_state[0] == 1 || m_state[1] == 1);
   endfunction

   function automatic bit m_anyfull();
      return m_state[0] == 2 || m_state[1] == 2;
   endfunction

   function automatic int m_csr(input int a);
      case (a)
         0: return m_state[0];
         1: return m_len[0];
         2: return m_state[1];
         3: return m_len[1];
         4: return DROP_EN ? m_drop : 0;
         5: return (m_rr ? 2 : 0) + (m_recv ? 1 : 0);
         default: return 0;
      endcase
   endfunction

   task automatic m_reset();
      m_state[0] = 0; m_state[1] = 0;
      m_len[0] = 0;   m_len[1] = 0;
      m_drop = 0; m_rr = 0; m_recv = 0; m_sel = 0;
   endtask

   task automatic m_write(input int a, input int d);
      int s;
      if (a == 0 || a == 2) begin
         s = a / 2;
         if ((d & 3) <= 1 && !(m_recv && m_sel == s))
            m_state[s] = d & 3;
      end else if (a == 4) begin
         m_drop = 0;
      end
   endtask

   task automatic m_drop_inc();
      if (m_drop < 65535) m_drop++;
   endtask

   task automatic m_accept();
      if (m_state[0] == 1 && m_state[1] == 1) begin
         m_sel = m_rr;
         m_rr = !m_rr;
      end else begin
         m_sel = (m_state[0] == 1) ? 1'b0 : 1'b1;
      end
      m_recv = 1;
   endtask

   // One clock; irq must reflect the FULL flags held before this edge.
   task automatic step();
      bit e;
      e = m_anyfull();
      @(posedge sys_clk);
      #1;
      chk("irq", {31'd0, irq}, {31'd0, e});
   endtask

   task automatic csr_write(input int a, input int d);
      csr_we = 1'b1; csr_adr = 3'(a); csr_di = d;
      step();
      csr_we = 1'b0;
      m_write(a, d);
   endtask

   task automatic read_chk(input int a);
      csr_adr = 3'(a);
      step();
      chk($sformatf("csr[%0d]", a), csr_do, m_csr(a));
   endtask

   // Full frame: start, optional mid-frame write, status read, end (0 done, 1 err, 2 both).
   task automatic frame(input int len, input int kind, input int mid_adr, input int mid_val,
                        input int endw_adr, input int endw_val);
      bit acc;
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_ready()});
      acc = m_ready();
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      if (acc) m_accept(); else m_drop_inc();
      chk("rx_active", {31'd0, rx_active}, {31'd0, m_recv});
      $display("frame: len=%0d kind=%0d accepted=%0d slot=%0d", len, kind, acc, m_sel);
      if (!acc) return;
      chk("rx_slot_sel", {31'd0, rx_slot_sel}, {31'd0, m_sel});
      if (mid_adr >= 0) csr_write(mid_adr, mid_val);
      read_chk(5);
      chk("rx_ready_recv", {31'd0, rx_ready}, 32'd0);
      chk("rx_slot_sel_hold", {31'd0, rx_slot_sel}, {31'd0, m_sel});
      rx_len = 11'(len);
      rx_done = (kind != 1);
      rx_err = (kind != 0);
      if (endw_adr >= 0) begin
         csr_we = 1'b1; csr_adr = 3'(endw_adr); csr_di = endw_val;
      end
      step();
      rx_done = 1'b0; rx_err = 1'b0; csr_we = 1'b0;
      if (endw_adr >= 0) m_write(endw_adr, endw_val);
      if (kind == 0 && len != 0) begin
         m_state[m_sel] = 2;
         m_len[m_sel] = len;
      end
      m_recv = 0;
      chk("rx_active_end", {31'd0, rx_active}, 32'd0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 8; a++) read_chk(a);
   endtask

   initial begin
      int r, ln, kd, ma, mv, ea, ev;
      m_reset();
      #1;
      chk("rst_csr_do", csr_do, 32'd0);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_rx_active", {31'd0, rx_active}, 32'd0);
      chk("rst_rx_slot_sel", {31'd0, rx_slot_sel}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      step();
      read_all();

      // Single frame into slot0
      csr_write(0, 1);
      frame(64, 0, -1, 0, -1, 0);
      read_chk(0);
      chk("s0_full_const", csr_do, 32'd2);
      read_chk(1);
      chk("s0_len_const", csr_do, 32'd64);

      // Round-robin over both slots with release after each frame
      csr_write(0, 1);
      csr_write(2, 1);
      for (int i = 0; i < 3; i++) begin
         frame(100, 0, -1, 0, -1, 0);
         chk("rr_slot_seq", {31'd0, m_sel}, (i == 1) ? 32'd1 : 32'd0);
         csr_write(2 * m_sel, 1);
      end
      read_all();

      // Drops with nothing armed, then clear, then clear colliding with a drop
      csr_write(0, 0);
      csr_write(2, 0);
      for (int i = 0; i < 5; i++) frame(10, 0, -1, 0, -1, 0);
      read_chk(4);
      csr_write(4, 0);
      read_chk(4);
      for (int i = 0; i < 2; i++) frame(10, 0, -1, 0, -1, 0);
      csr_we = 1'b1; csr_adr = 3'd4; rx_start = 1'b1;
      step();
      csr_we = 1'b0; rx_start = 1'b0;
      m_write(4, 0);
      m_drop_inc();
      read_chk(4);

      // Mid-frame disable of the owned slot is ignored; rx_err keeps it armed
      csr_write(2, 1);
      frame(300, 1, 2, 0, -1, 0);
      read_chk(2);
      read_chk(3);

      // done+err together behaves as err
      csr_write(2, 0);
      csr_write(0, 1);
      frame(200, 2, -1, 0, -1, 0);
      read_chk(0);
      read_chk(1);

      // Commit on slot0 while software arms slot1 in the same cycle
      frame(77, 0, -1, 0, 2, 1);
      read_all();

      // Async reset in the middle of a frame owning slot1
      csr_write(0, 0);
      frame(500, 0, -1, 0, -1, 0);
      csr_write(2, 1);
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      m_accept();
      chk("pre_rst_sel", {31'd0, rx_slot_sel}, 32'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      m_reset();
      chk("arst_rx_active", {31'd0, rx_active}, 32'd0);
      chk("arst_rx_slot_sel", {31'd0, rx_slot_sel}, 32'd0);
      chk("arst_irq", {31'd0, irq}, 32'd0);
      chk("arst_csr_do", csr_do, 32'd0);
      chk("arst_rx_ready", {31'd0, rx_ready}, 32'd0);
      step();
      sys_rst_n = 1'b1;
      read_chk(0);
      read_chk(2);
      chk("post_rst_ready", {31'd0, rx_ready}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 1) begin
            mv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 1;
            csr_write(2 * $urandom_range(0, 1), mv);
         end else if (r == 2) begin
            csr_write($urandom_range(0, 7), $urandom);
         end else if (r <= 6) begin
            ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2047);
            kd = $urandom_range(0, 9);
            kd = (kd < 6) ? 0 : ((kd < 8) ? 1 : 2);
            ma = ($urandom_range(0, 2) == 0) ? 2 * $urandom_range(0, 1) : -1;
            mv = $urandom_range(0, 3);
            ea = ($urandom_range(0, 2) == 0) ? 2 * $urandom_range(0, 1) : -1;
            ev = $urandom_range(0, 3);
            frame(ln, kd, ma, mv, ea, ev);
         end else if (r <= 8) begin
            read_chk($urandom_range(0, 7));
         end else begin
            step();
         end
      end
      read_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
